// File: rtl/fetch_stage_if.sv
// Instruction-memory request bus between the fetch stage (master) and the
// instruction memory (slave).
interface fetch_stage_if;
    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic [31:0] Imem_Rdata;
    logic        Imem_Ready;

    modport master (
        output Imem_Req,
        output Imem_Addr,
        input  Imem_Rdata,
        input  Imem_Ready
    );

    modport slave (
        input  Imem_Req,
        input  Imem_Addr,
        output Imem_Rdata,
        output Imem_Ready
    );
endinterface

// File: rtl/fetch_stage.sv
// Pipeline fetch stage: PC register, instruction-memory request FSM, one-entry
// hold buffer for stalled words, deferred redirect, and the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 StallF,
    input  logic                 StallD,
    input  logic                 FlushD,
    input  logic                 PCSrc_E,
    input  logic [31:0]          PC_Target_E,
    fetch_stage_if.master        imem,
    output logic [31:0]          Instr_D,
    output logic [31:0]          PC_D,
    output logic [31:0]          PCPlus4_D,
    output logic                 Valid_D
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        vld_q, vld_d;

    logic        req_s;
    logic        done_s;
    logic        outstanding_s;
    logic [31:0] tgt_s;
    logic        deliver_s;
    logic [31:0] word_s;
    logic        consume_s;

    // Request/handshake decode and selection of the word offered to decode.
    always_comb begin
        req_s         = (state_q != BOOT) && !hold_vld_q;
        done_s        = req_s && imem.Imem_Ready;
        outstanding_s = req_s && !imem.Imem_Ready;
        tgt_s         = {PC_Target_E[31:2], 2'b00};
        // A word returning for a redirected-away PC is never offered.
        if (hold_vld_q) begin
            deliver_s = !PCSrc_E;
            word_s    = hold_q;
        end else begin
            deliver_s = done_s && !pend_q && !PCSrc_E;
            word_s    = imem.Imem_Rdata;
        end
        consume_s = deliver_s && !StallF && !StallD && !FlushD;
    end

    // Next-state for FSM, PC, hold buffer and deferred redirect.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        case (state_q)
            BOOT:    state_d = REQ;
            REQ:     state_d = outstanding_s ? WAIT : REQ;
            WAIT:    state_d = imem.Imem_Ready ? REQ : WAIT;
            default: state_d = BOOT;
        endcase
        // PC must stay put while a request is in flight, so redirects wait.
        if (PCSrc_E && outstanding_s) begin
            pend_d     = 1'b1;
            pend_tgt_d = tgt_s;
        end else if (PCSrc_E) begin
            pc_d       = tgt_s;
            hold_vld_d = 1'b0;
            pend_d     = 1'b0;
        end else if (done_s && pend_q) begin
            pc_d   = pend_tgt_q;
            pend_d = 1'b0;
        end else if (consume_s) begin
            pc_d       = pc_q + 32'd4;
            hold_vld_d = 1'b0;
        end else if (done_s) begin
            hold_d     = imem.Imem_Rdata;
            hold_vld_d = 1'b1;
        end else begin
            hold_vld_d = hold_vld_q;
        end
    end

    // IF/ID next value: flush beats stall, stall beats load.
    always_comb begin
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pcp4_d  = pcp4_q;
        vld_d   = vld_q;
        if (FlushD) begin
            instr_d = NOP_INSTR;
            pcd_d   = 32'd0;
            pcp4_d  = 32'd0;
            vld_d   = 1'b0;
        end else if (StallD) begin
            vld_d = vld_q;
        end else if (consume_s) begin
            instr_d = word_s;
            pcd_d   = pc_q;
            pcp4_d  = pc_q + 32'd4;
            vld_d   = 1'b1;
        end else begin
            instr_d = NOP_INSTR;
            vld_d   = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            hold_q     <= 32'd0;
            hold_vld_q <= 1'b0;
            pend_q     <= 1'b0;
            pend_tgt_q <= 32'd0;
            instr_q    <= NOP_INSTR;
            pcd_q      <= 32'd0;
            pcp4_q     <= 32'd0;
            vld_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            instr_q    <= instr_d;
            pcd_q      <= pcd_d;
            pcp4_q     <= pcp4_d;
            vld_q      <= vld_d;
        end
    end

    assign imem.Imem_Req  = req_s;
    assign imem.Imem_Addr = pc_q;
    assign Instr_D        = instr_q;
    assign PC_D           = pcd_q;
    assign PCPlus4_D      = pcp4_q;
    assign Valid_D        = vld_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic, with a
// program-order scoreboard checking every instruction that enters IF/ID.
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrc_E = 1'b0;
    logic [31:0] PC_Target_E = 32'd0;
    logic [31:0] Instr_D, PC_D, PCPlus4_D;
    logic        Valid_D;
    logic [31:0] junk = 32'hDEAD_BEEF;

    int errors = 0;
    int checks = 0;
    int delivered = 0;
    logic [31:0] exp_q[$];
    logic [31:0] prog_pc = RESET_PC;

    fetch_stage_if imem_if ();

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .PCSrc_E(PCSrc_E), .PC_Target_E(PC_Target_E),
        .imem(imem_if), .Instr_D(Instr_D), .PC_D(PC_D),
        .PCPlus4_D(PCPlus4_D), .Valid_D(Valid_D)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // Instruction memory: contents are a fixed function of the address.
    always_comb imem_if.Imem_Rdata = imem_if.Imem_Ready ? mem_word(imem_if.Imem_Addr) : junk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; a redirect restarts the expected program stream.
    task automatic cyc(input logic rdy, input logic sf, input logic sd, input logic fl,
                       input logic pcs, input logic [31:0] tgt);
        @(negedge clk);
        imem_if.Imem_Ready = rdy;
        StallF = sf; StallD = sd; FlushD = fl; PCSrc_E = pcs; PC_Target_E = tgt;
        junk = $urandom;
        if (pcs) begin
            exp_q.delete();
            prog_pc = {tgt[31:2], 2'b00};
        end
        while (exp_q.size() < 8) begin
            exp_q.push_back(prog_pc);
            prog_pc = prog_pc + 32'd4;
        end
        @(posedge clk); #1;
    endtask

    task automatic reset_assert();
        rst_n = 1'b0;
        imem_if.Imem_Ready = 1'b0;
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrc_E = 1'b0; PC_Target_E = 32'd0;
        exp_q.delete();
        prog_pc = RESET_PC;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, imem_if.Imem_Req, 1'b0);
        chk({tag, "_addr"}, imem_if.Imem_Addr, RESET_PC);
        chk({tag, "_instr"}, Instr_D, NOP_INSTR);
        chk({tag, "_pcd"}, PC_D, 32'd0);
        chk({tag, "_pcp4"}, PCPlus4_D, 32'd0);
        chk({tag, "_valid"}, Valid_D, 1'b0);
    endtask

    // Monitor: every fresh IF/ID load must be the next instruction in program order.
    initial begin
        logic        pre_ok, pre_out;
        logic [31:0] pre_addr, e;
        forever begin
            @(negedge clk); #2;
            pre_ok   = rst_n;
            pre_out  = imem_if.Imem_Req && !imem_if.Imem_Ready;
            pre_addr = imem_if.Imem_Addr;
            @(posedge clk); #1;
            if (rst_n && pre_ok) begin
                if (pre_out) chk("addr_stable", imem_if.Imem_Addr, pre_addr);
                if (!StallD && !FlushD && Valid_D) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL sb_empty: got pc %h expected none at %0t", PC_D, $time);
                    end else begin
                        e = exp_q.pop_front();
                        delivered++;
                        chk("sb_pc", PC_D, e);
                        chk("sb_instr", Instr_D, mem_word(e));
                        chk("sb_pcp4", PCPlus4_D, e + 32'd4);
                    end
                end else if (!Valid_D) begin
                    chk("sb_bubble", Instr_D, NOP_INSTR);
                end
            end
        end
    end

    initial begin
        logic pcs;
        #1;
        reset_assert();
        #1;
        check_reset_outputs("rst");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("boot_req", imem_if.Imem_Req, 1'b0);
        @(posedge clk); #1;
        chk("first_req", imem_if.Imem_Req, 1'b1);
        chk("first_addr", imem_if.Imem_Addr, 32'h0);

        // Back-to-back fetches W0, W1.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("w0_instr", Instr_D, mem_word(32'h0));
        chk("w0_pcd", PC_D, 32'h0);
        chk("w0_pcp4", PCPlus4_D, 32'h4);
        chk("w0_valid", Valid_D, 1'b1);
        chk("w0_addr", imem_if.Imem_Addr, 32'h4);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("w1_instr", Instr_D, mem_word(32'h4));
        chk("w1_pcd", PC_D, 32'h4);

        // Memory wait states at 0x8.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
            chk("wait_addr", imem_if.Imem_Addr, 32'h8);
            chk("wait_valid", Valid_D, 1'b0);
            chk("wait_instr", Instr_D, NOP_INSTR);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("wait_done_instr", Instr_D, mem_word(32'h8));
        chk("wait_done_pcd", PC_D, 32'h8);

        // Stall during completion at 0xC.
        for (int i = 0; i < 2; i++) begin
            cyc(i == 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
            chk("stall_req", imem_if.Imem_Req, 1'b0);
            chk("stall_instr", Instr_D, mem_word(32'h8));
            chk("stall_pcd", PC_D, 32'h8);
            chk("stall_addr", imem_if.Imem_Addr, 32'hC);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("held_instr", Instr_D, mem_word(32'hC));
        chk("held_pcd", PC_D, 32'hC);
        chk("held_next_addr", imem_if.Imem_Addr, 32'h10);
        chk("held_next_req", imem_if.Imem_Req, 1'b1);

        // Redirect while a request is outstanding at 0x20.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("pre_redir_addr", imem_if.Imem_Addr, 32'h20);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0103);
        chk("redir_pend_addr", imem_if.Imem_Addr, 32'h20);
        chk("redir_pend_valid", Valid_D, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("redir_pend_addr2", imem_if.Imem_Addr, 32'h20);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("redir_drop_addr", imem_if.Imem_Addr, 32'h100);
        chk("redir_drop_valid", Valid_D, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("redir_tgt_pcd", PC_D, 32'h100);
        chk("redir_tgt_instr", Instr_D, mem_word(32'h100));

        // Redirect overriding StallF, with decode flushed.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0200);
        chk("redir_sf_addr", imem_if.Imem_Addr, 32'h200);
        chk("redir_sf_instr", Instr_D, NOP_INSTR);
        chk("redir_sf_valid", Valid_D, 1'b0);

        // Asynchronous reset while waiting on memory.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("pre_rst_addr", imem_if.Imem_Addr, 32'h200);
        #2;
        reset_assert();
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_boot_req", imem_if.Imem_Req, 1'b0);
        @(posedge clk); #1;
        chk("midrst_restart_req", imem_if.Imem_Req, 1'b1);
        chk("midrst_restart_addr", imem_if.Imem_Addr, RESET_PC);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("midrst_first_pcd", PC_D, RESET_PC);

        // Randomized traffic; redirects always come with a decode flush.
        for (int i = 0; i < 3000; i++) begin
            pcs = ($urandom_range(0, 99) < 4);
            cyc($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 15,
                $urandom_range(0, 99) < 15, pcs, pcs, $urandom);
        end
        checks++;
        if (delivered < 300) begin
            errors++;
            $display("FAIL progress: got %0d delivered expected at least 300", delivered);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
